// File: rtl/io_bus_switch.sv
// io_bus_switch: routes the CPU I/O bus to NSLAVE devices, merges per-slave
// interrupt levels, and turns runaway retry runs into bus errors.
// Optional build macro IO_SWITCH_STATS_EN adds access/retry statistics
// counters readable at the two topmost word addresses.
module io_bus_switch #(
  parameter int unsigned NTHREAD     = 64,
  parameter int unsigned NSLAVE      = 4,
  parameter int unsigned RETRY_LIMIT = 15,
  parameter int unsigned IO_AWIDTH   = 20,
  parameter int unsigned IO_DWIDTH   = 32,
  localparam int unsigned TW = $clog2(NTHREAD),
  localparam int unsigned SW = $clog2(NSLAVE),
  localparam int unsigned BW = IO_DWIDTH / 8,
  localparam int unsigned LW = IO_AWIDTH - SW
) (
  input  logic                        gclk,
  input  logic                        rst,
  input  logic [TW-1:0]               cpu_tid,
  input  logic [IO_AWIDTH-1:0]        cpu_addr,
  input  logic [IO_DWIDTH-1:0]        cpu_wdata,
  input  logic                        cpu_rw,
  input  logic                        cpu_en,
  input  logic                        cpu_replay,
  input  logic [BW-1:0]               cpu_we,
  output logic [3:0]                  cpu_irl,
  output logic [IO_DWIDTH-1:0]        cpu_rdata,
  output logic                        cpu_retry,
  output logic                        cpu_err,
  output logic [TW-1:0]               cpu_err_tid,
  output logic [TW-1:0]               slv_tid,
  input  logic [4*NSLAVE-1:0]         slv_irl,
  output logic [NSLAVE-1:0]           slv_req,
  output logic [LW-1:0]               slv_addr,
  output logic [IO_DWIDTH-1:0]        slv_wdata,
  output logic                        slv_rw,
  output logic [BW-1:0]               slv_we,
  output logic [TW-1:0]               slv_tid_xc,
  input  logic [IO_DWIDTH*NSLAVE-1:0] slv_rdata,
  input  logic [NSLAVE-1:0]           slv_busy
);

  logic [TW-1:0]        tid_m2;
  logic [TW-1:0]        tid_x;
  logic [SW-1:0]        sel_x;
  logic [LW-1:0]        addr_x;
  logic [3:0]           cnt [NTHREAD];
  logic [3:0]           eff_cnt;
  logic                 at_limit;
  logic                 busy;
  logic                 stat_hit;
  logic [IO_DWIDTH-1:0] stat_rdata;
  logic [IO_DWIDTH-1:0] rdata_sel;

  // IRL lookup is broadcast straight from the M1 thread id
  assign slv_tid = rst ? '0 : cpu_tid;

  // Merge per-slave interrupt levels: highest nibble wins
  always_comb begin
    cpu_irl = '0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (slv_irl[4*i +: 4] > cpu_irl) cpu_irl = slv_irl[4*i +: 4];
    end
    if (rst) cpu_irl = '0;
  end

  // Read data mux for the decoded slave
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (sel_x == SW'(i)) rdata_sel = slv_rdata[IO_DWIDTH*i +: IO_DWIDTH];
    end
  end

  // A non-replay issue is a new instruction, so its retry run starts over
  assign eff_cnt  = cpu_replay ? cnt[tid_x] : 4'd0;
  assign at_limit = ({1'b0, eff_cnt} + 5'd1) >= 5'(RETRY_LIMIT);
  assign busy     = slv_busy[sel_x] & ~stat_hit;

`ifdef IO_SWITCH_STATS_EN
  localparam logic [IO_AWIDTH-1:0] ACC_ADDR = {{(IO_AWIDTH-4){1'b1}}, 4'h8};
  localparam logic [IO_AWIDTH-1:0] RTY_ADDR = {{(IO_AWIDTH-4){1'b1}}, 4'hC};

  logic [31:0] acc_cnt;
  logic [31:0] rty_cnt;
  logic        acc_hit;
  logic        rty_hit;

  assign acc_hit    = {sel_x, addr_x} == ACC_ADDR;
  assign rty_hit    = {sel_x, addr_x} == RTY_ADDR;
  assign stat_hit   = acc_hit | rty_hit;
  assign stat_rdata = acc_hit ? IO_DWIDTH'(acc_cnt) : IO_DWIDTH'(rty_cnt);

  // Statistics counters; a write to a counter's address clears it
  always_ff @(posedge gclk) begin
    if (rst) begin
      acc_cnt <= 32'd0;
      rty_cnt <= 32'd0;
    end else begin
      if (cpu_en && cpu_rw && acc_hit)  acc_cnt <= 32'd0;
      else if (cpu_en && !busy)         acc_cnt <= acc_cnt + 32'd1;
      if (cpu_en && cpu_rw && rty_hit)  rty_cnt <= 32'd0;
      else if (cpu_retry || cpu_err)    rty_cnt <= rty_cnt + 32'd1;
    end
  end
`else
  assign stat_hit   = 1'b0;
  assign stat_rdata = '0;
`endif

  // XC stage: request strobe, pass-through, retry/error resolution
  always_comb begin
    slv_req     = '0;
    slv_addr    = '0;
    slv_wdata   = '0;
    slv_rw      = 1'b0;
    slv_we      = '0;
    slv_tid_xc  = '0;
    cpu_rdata   = '0;
    cpu_retry   = 1'b0;
    cpu_err     = 1'b0;
    cpu_err_tid = '0;
    if (!rst) begin
      slv_addr    = addr_x;
      slv_wdata   = cpu_wdata;
      slv_rw      = cpu_rw;
      slv_we      = cpu_we;
      slv_tid_xc  = tid_x;
      cpu_err_tid = tid_x;
      if (cpu_en) begin
        if (!stat_hit) slv_req[sel_x] = 1'b1;
        if (busy) begin
          cpu_err   = at_limit;
          cpu_retry = ~at_limit;
        end else if (!cpu_rw) begin
          cpu_rdata = stat_hit ? stat_rdata : rdata_sel;
        end
      end
    end
  end

  // M1->M2->XC pipeline and per-thread retry counters
  always_ff @(posedge gclk) begin
    if (rst) begin
      tid_m2 <= '0;
      tid_x  <= '0;
      sel_x  <= '0;
      addr_x <= '0;
      for (int t = 0; t < int'(NTHREAD); t++) cnt[t] <= 4'd0;
    end else begin
      tid_m2 <= cpu_tid;
      tid_x  <= tid_m2;
      sel_x  <= cpu_addr[IO_AWIDTH-1 -: SW];
      addr_x <= cpu_addr[LW-1:0];
      if (cpu_en) begin
        if (busy && !at_limit) cnt[tid_x] <= eff_cnt + 4'd1;
        else                   cnt[tid_x] <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_switch.sv
// tb_io_bus_switch: directed stimulus with a scoreboard of expected XC results.
module tb_io_bus_switch;

  localparam int LIM = 15;

  logic         gclk;
  logic         rst;
  logic [5:0]   cpu_tid;
  logic [19:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_rw;
  logic         cpu_en;
  logic         cpu_replay;
  logic [3:0]   cpu_we;
  logic [3:0]   cpu_irl;
  logic [31:0]  cpu_rdata;
  logic         cpu_retry;
  logic         cpu_err;
  logic [5:0]   cpu_err_tid;
  logic [5:0]   slv_tid;
  logic [15:0]  slv_irl;
  logic [3:0]   slv_req;
  logic [17:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic         slv_rw;
  logic [3:0]   slv_we;
  logic [5:0]   slv_tid_xc;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_busy;

  io_bus_switch dut (
    .gclk(gclk), .rst(rst), .cpu_tid(cpu_tid), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw), .cpu_en(cpu_en),
    .cpu_replay(cpu_replay), .cpu_we(cpu_we), .cpu_irl(cpu_irl),
    .cpu_rdata(cpu_rdata), .cpu_retry(cpu_retry), .cpu_err(cpu_err),
    .cpu_err_tid(cpu_err_tid), .slv_tid(slv_tid), .slv_irl(slv_irl),
    .slv_req(slv_req), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rw(slv_rw), .slv_we(slv_we), .slv_tid_xc(slv_tid_xc),
    .slv_rdata(slv_rdata), .slv_busy(slv_busy)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct {
    logic         valid;
    logic [5:0]   tid;
    logic [19:0]  addr;
    logic         rw;
    logic         replay;
    logic [31:0]  wdata;
    logic [3:0]   we;
    logic [3:0]   busy;
    logic [127:0] rdata;
  } req_t;

  typedef struct {
    logic [3:0]  req;
    logic [17:0] addr;
    logic [5:0]  tid;
    logic [31:0] rdata;
    logic        retry;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  req_t       m1, m2, xc, idle_r;
  logic [3:0] mcnt [64];
  logic [31:0] macc, mrty;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic req_t mk(input logic [5:0] tid, input logic [19:0] addr, input logic rw,
                              input logic replay, input logic [3:0] busy, input logic [31:0] rd);
    req_t r;
    int   s;
    r.valid  = 1'b1;
    r.tid    = tid;
    r.addr   = addr;
    r.rw     = rw;
    r.replay = replay;
    r.wdata  = $urandom;
    r.we     = 4'($urandom);
    r.busy   = busy;
    for (int i = 0; i < 4; i++) r.rdata[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
    s = int'(addr[19:18]);
    r.rdata[s*32 +: 32] = rd;
    return r;
  endfunction

  // Reference behaviour of one XC transaction, applied in issue order
  task automatic push_exp(input req_t r);
    exp_t       e;
    int         s;
    logic       stat, bsy;
    logic [3:0] eff;
    s = int'(r.addr[19:18]);
    stat = 1'b0;
`ifdef IO_SWITCH_STATS_EN
    stat = (r.addr == 20'hFFFF8) || (r.addr == 20'hFFFFC);
`endif
    e.req   = stat ? 4'b0000 : (4'b0001 << s);
    e.addr  = r.addr[17:0];
    e.tid   = r.tid;
    e.rdata = 32'd0;
    e.retry = 1'b0;
    e.err   = 1'b0;
    bsy = r.busy[s] && !stat;
    eff = r.replay ? mcnt[r.tid] : 4'd0;
    if (bsy) begin
      if (int'(eff) + 1 >= LIM) begin
        e.err = 1'b1;
        mcnt[r.tid] = 4'd0;
      end else begin
        e.retry = 1'b1;
        mcnt[r.tid] = eff + 4'd1;
      end
    end else begin
      mcnt[r.tid] = 4'd0;
      if (!r.rw) e.rdata = stat ? ((r.addr == 20'hFFFF8) ? macc : mrty) : r.rdata[s*32 +: 32];
    end
`ifdef IO_SWITCH_STATS_EN
    if (r.rw && r.addr == 20'hFFFF8) macc = 32'd0;
    else if (!bsy)                   macc = macc + 32'd1;
    if (r.rw && r.addr == 20'hFFFFC) mrty = 32'd0;
    else if (bsy)                    mrty = mrty + 32'd1;
`endif
    exp_q.push_back(e);
  endtask

  // Advance one cycle: r enters M1, older requests move to M2/XC
  task automatic tick(input req_t r, input logic do_rst);
    exp_t e;
    xc = m2;
    m2 = m1;
    m1 = r;
    @(posedge gclk);
    #1;
    rst        = do_rst;
    cpu_tid    = m1.tid;
    cpu_addr   = m2.addr;
    cpu_en     = xc.valid;
    cpu_rw     = xc.rw;
    cpu_replay = xc.replay;
    cpu_wdata  = xc.wdata;
    cpu_we     = xc.we;
    slv_busy   = xc.busy;
    slv_rdata  = xc.rdata;
    @(negedge gclk);
    if (do_rst) begin
      chk("rst_req", 32'(slv_req), 32'd0);
      chk("rst_retry", 32'(cpu_retry), 32'd0);
      chk("rst_err", 32'(cpu_err), 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      if (xc.valid && exp_q.size() > 0) void'(exp_q.pop_front());
      for (int t = 0; t < 64; t++) mcnt[t] = 4'd0;
      macc = 32'd0;
      mrty = 32'd0;
    end else if (xc.valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("slv_req", 32'(slv_req), 32'(e.req));
        chk("slv_addr", 32'(slv_addr), 32'(e.addr));
        chk("slv_tid_xc", 32'(slv_tid_xc), 32'(e.tid));
        chk("cpu_err_tid", 32'(cpu_err_tid), 32'(e.tid));
        chk("cpu_rdata", cpu_rdata, e.rdata);
        chk("cpu_retry", 32'(cpu_retry), 32'(e.retry));
        chk("cpu_err", 32'(cpu_err), 32'(e.err));
        chk("slv_wdata", slv_wdata, xc.wdata);
        chk("slv_we", 32'(slv_we), 32'(xc.we));
        chk("slv_rw", 32'(slv_rw), 32'(xc.rw));
      end
    end else begin
      chk("idle_req", 32'(slv_req), 32'd0);
      chk("idle_retry", 32'(cpu_retry), 32'd0);
      chk("idle_err", 32'(cpu_err), 32'd0);
      chk("idle_rdata", cpu_rdata, 32'd0);
    end
  endtask

  task automatic issue(input logic [5:0] tid, input logic [19:0] addr, input logic rw,
                       input logic replay, input logic [3:0] busy, input logic [31:0] rd);
    req_t r;
    r = mk(tid, addr, rw, replay, busy, rd);
    push_exp(r);
    tick(r, 1'b0);
  endtask

  task automatic flush();
    tick(idle_r, 1'b0);
    tick(idle_r, 1'b0);
  endtask

  initial begin
    idle_r = '{valid: 1'b0, tid: 6'h2A, addr: 20'hABCDE, rw: 1'b0, replay: 1'b0,
               wdata: 32'd0, we: 4'd0, busy: 4'd0, rdata: 128'd0};
    m1 = idle_r;
    m2 = idle_r;
    xc = idle_r;
    for (int t = 0; t < 64; t++) mcnt[t] = 4'd0;
    macc = 32'd0;
    mrty = 32'd0;

    // Reset state
    rst = 1'b1; cpu_tid = 6'h15; cpu_addr = 20'h80010; cpu_wdata = 32'd0;
    cpu_rw = 1'b0; cpu_en = 1'b1; cpu_replay = 1'b0; cpu_we = 4'd0;
    slv_irl = 16'h0F00; slv_rdata = '1; slv_busy = 4'b0000;
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    chk("reset_req", 32'(slv_req), 32'd0);
    chk("reset_retry", 32'(cpu_retry), 32'd0);
    chk("reset_err", 32'(cpu_err), 32'd0);
    chk("reset_irl", 32'(cpu_irl), 32'd0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    chk("reset_slv_tid", 32'(slv_tid), 32'd0);
    slv_irl = 16'h0000;
    tick(idle_r, 1'b0);
    tick(idle_r, 1'b0);

    // Read to slave 2, then one with unrelated slaves busy
    issue(6'd1, 20'h80010, 1'b0, 1'b0, 4'b0000, 32'h1234_5678);
    issue(6'd2, 20'h80abc, 1'b0, 1'b0, 4'b1011, 32'h0BAD_F00D);
    flush();

    // Back-to-back, no bubbles
    issue(6'd3, 20'h00020, 1'b0, 1'b0, 4'b0000, 32'hA0A0_0003);
    issue(6'd7, 20'h40024, 1'b0, 1'b0, 4'b0000, 32'hB1B1_0007);
    issue(6'd9, 20'hC0100, 1'b1, 1'b0, 4'b0000, 32'hC2C2_0009);
    flush();

    // Retry limit: 14 retries, error on the 15th, fresh retry on the 16th
    for (int i = 0; i < 16; i++)
      issue(6'd5, 20'h40008, 1'b0, (i != 0), 4'b0010, 32'h5555_0000 + 32'(i));
    flush();

    // Retries then success with another thread interleaved
    issue(6'd5, 20'h40008, 1'b0, 1'b0, 4'b0010, 32'h1);
    issue(6'd6, 20'h40008, 1'b0, 1'b0, 4'b0010, 32'h2);
    issue(6'd5, 20'h40008, 1'b0, 1'b1, 4'b0010, 32'h3);
    issue(6'd6, 20'h40008, 1'b0, 1'b1, 4'b0010, 32'h4);
    issue(6'd5, 20'h40008, 1'b0, 1'b1, 4'b0010, 32'h5);
    issue(6'd5, 20'h40008, 1'b0, 1'b1, 4'b0000, 32'h6666_0005);
    issue(6'd5, 20'h40008, 1'b0, 1'b0, 4'b0010, 32'h7);
    for (int i = 0; i < 14; i++)
      issue(6'd5, 20'h40008, 1'b0, 1'b1, 4'b0010, 32'h8);
    flush();

    // Interrupt level merge (combinational)
    chk("slv_tid", 32'(slv_tid), 32'h2A);
    slv_irl = {4'h3, 4'h0, 4'hA, 4'h1};
    #1 chk("irl_max", 32'(cpu_irl), 32'hA);
    slv_irl = 16'h0000;
    #1 chk("irl_zero", 32'(cpu_irl), 32'h0);
    slv_irl = {4'hF, 4'h0, 4'h7, 4'h0};
    #1 chk("irl_top", 32'(cpu_irl), 32'hF);
    slv_irl = 16'h0000;

    // Reset while a busy request that would hit the limit is in XC
    issue(6'd5, 20'h40008, 1'b0, 1'b0, 4'b0010, 32'h0);
    for (int i = 0; i < 13; i++)
      issue(6'd5, 20'h40008, 1'b0, 1'b1, 4'b0010, 32'h0);
    begin
      req_t r;
      r = mk(6'd5, 20'h40008, 1'b0, 1'b1, 4'b0010, 32'h0);
      push_exp(r);
      tick(r, 1'b0);
      tick(idle_r, 1'b0);
      tick(idle_r, 1'b1);
    end
    tick(idle_r, 1'b0);
    chk("post_rst_tid_x", 32'(slv_tid_xc), 32'd0);
    chk("post_rst_addr", 32'(slv_addr), 32'd0);
    chk("post_rst_err_tid", 32'(cpu_err_tid), 32'd0);
    tick(idle_r, 1'b0);

`ifdef IO_SWITCH_STATS_EN
    // Statistics: 3 successes and 2 retries since reset
    for (int i = 0; i < 3; i++)
      issue(6'd1, 20'h00040, 1'b0, 1'b0, 4'b0000, 32'h1000 + 32'(i));
    issue(6'd8, 20'h40000, 1'b0, 1'b0, 4'b0010, 32'h0);
    issue(6'd8, 20'h40000, 1'b0, 1'b1, 4'b0010, 32'h0);
    issue(6'd1, 20'hFFFF8, 1'b0, 1'b0, 4'b1111, 32'h0);
    issue(6'd1, 20'hFFFFC, 1'b0, 1'b0, 4'b1111, 32'h0);
    issue(6'd1, 20'hFFFFC, 1'b1, 1'b0, 4'b1111, 32'h0);
    issue(6'd1, 20'hFFFFC, 1'b0, 1'b0, 4'b1111, 32'h0);
    flush();
`endif

    // Counter cleared by reset: a replay hit is a plain retry
    issue(6'd5, 20'h40008, 1'b0, 1'b1, 4'b0010, 32'h0);
    flush();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_switch.md
Name: io_bus_switch

Overview:
- Routes the CPU I/O bus to NSLAVE I/O devices: decodes the address, forwards the request to one slave, and muxes read data and retry back to the CPU.
- Merges per-slave interrupt levels into a single IRL for the issuing thread.
- Counts consecutive retries per thread, and converts a retry run that reaches RETRY_LIMIT into a bus error so an unresponsive device cannot livelock a thread.
- Sits between the integer pipeline's memory/exception stages and the I/O device bank.

Parameters:
- NTHREAD, 64, number of hardware threads; TW = log2(NTHREAD).
- NSLAVE, 4, number of slave ports (power of 2); SW = log2(NSLAVE).
- RETRY_LIMIT, 15, consecutive retries before a bus error (1..15; 4-bit counters).
- IO_AWIDTH, 20, I/O address width.
- IO_DWIDTH, 32, I/O data width.

Ports:
- gclk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- cpu_tid  in  TW  thread id, valid in M1.
- cpu_addr  in  IO_AWIDTH  address, valid in M2.
- cpu_wdata  in  IO_DWIDTH  write data, valid in XC.
- cpu_rw  in  1  0=read, 1=write, valid in XC.
- cpu_en  in  1  request valid, in XC.
- cpu_replay  in  1  replayed instruction, in XC.
- cpu_we  in  IO_DWIDTH/8  byte enables, in XC.
- cpu_irl  out  4  merged interrupt level for cpu_tid (M1).
- cpu_rdata  out  IO_DWIDTH  read data (XC).
- cpu_retry  out  1  replay request (XC).
- cpu_err  out  1  bus-error pulse (XC).
- cpu_err_tid  out  TW  thread that took the error.
- slv_tid  out  TW  cpu_tid broadcast for IRL lookup.
- slv_irl  in  4*NSLAVE  per-slave IRL for slv_tid.
- slv_req  out  NSLAVE  one-hot request strobe (XC).
- slv_addr  out  IO_AWIDTH-SW  slave-local address.
- slv_wdata  out  IO_DWIDTH  write data.
- slv_rw  out  1  read/write.
- slv_we  out  IO_DWIDTH/8  byte enables.
- slv_tid_xc  out  TW  thread of the XC request.
- slv_rdata  in  IO_DWIDTH*NSLAVE  per-slave read data (combinational in XC).
- slv_busy  in  NSLAVE  slave cannot accept this cycle.

Behaviour:
- Reset: all pipeline registers cleared, all retry counters 0, and every output 0 (cpu_irl=0, cpu_retry=0, cpu_err=0, slv_req=0).
- IRL merge:
  - slv_tid = cpu_tid (combinational).
  - cpu_irl = numerically largest slv_irl nibble; ties are irrelevant.
  - Purely combinational, zero latency.
- M2 to XC pipeline, registered at the posedge ending M2:
  - tid_x <= tid_m2 (tid_m2 <= cpu_tid at the end of M1).
  - sel_x <= cpu_addr[IO_AWIDTH-1 -: SW].
  - addr_x <= cpu_addr[IO_AWIDTH-SW-1:0].
  - This is a two-deep tid shift; a new request may arrive every cycle with no bubbles.
- XC, combinational:
  - slv_req[sel_x] = cpu_en, and no other slv_req bit is set.
  - slv_addr = addr_x; slv_tid_xc = tid_x; wdata, rw and we pass through.
  - cpu_rdata = slv_rdata[sel_x] when cpu_en & ~cpu_rw & ~busy, else 0.
  - busy = slv_busy[sel_x].
  - cpu_retry = cpu_en & busy & ~(cnt[tid_x]+1 >= RETRY_LIMIT).
  - cpu_err = cpu_en & busy & (cnt[tid_x]+1 >= RETRY_LIMIT).
  - cpu_err_tid = tid_x.
  - When cpu_err=1: cpu_retry=0 and cpu_rdata=0.
- Retry counter cnt[tid_x], updated at the posedge ending XC:
  - cpu_en=0: unchanged.
  - cpu_en & ~busy: cleared to 0.
  - cpu_en & busy & cpu_err: cleared to 0, so the next access starts fresh.
  - cpu_en & busy & ~cpu_err: incremented by 1.
  - cpu_replay=0 with busy: count restarts at 1, since a non-replay issue is a new instruction.
  - Counters never wrap; RETRY_LIMIT bounds them.
- Simultaneous events: counters for different threads are independent. Only tid_x is touched per cycle, so there is no conflict.
- Reset mid-operation: synchronous reset takes priority over any update. An in-flight XC request during reset is dropped (slv_req=0 in the reset cycle).

Optional Feature:
- Macro: IO_SWITCH_STATS_EN.
- When defined:
  - Two 32-bit wrapping counters: acc_cnt, which increments on any cpu_en & ~busy, and rty_cnt, which increments on cpu_retry|cpu_err.
  - Reads with full address 0xFFFF8 return acc_cnt and 0xFFFFC return rty_cnt. These are intercepted before slave decode: slv_req=0, never busy.
  - Writes to these addresses clear the respective counter.
  - Both counters reset to 0.
- When undefined: no counters; those addresses go to the top slave as normal.

Test Plan:
- Read to slave 2: cpu_addr=0x80010, slv_rdata[2]=0x12345678, busy=0. Expect slv_req=4'b0100, slv_addr=0x00010, cpu_rdata=0x12345678, cpu_retry=0.
- Back-to-back requests from tid 3 then tid 7 in consecutive cycles to slaves 0 and 1. Expect slv_tid_xc=3 then 7, correct one-hot slv_req each cycle, no bubble.
- Thread 5 hits slv_busy[1]=1 on 14 consecutive replays: cpu_retry=1 each time. On the 15th: cpu_err=1, cpu_err_tid=5, cpu_retry=0. On the 16th: cpu_retry=1 again (counter restarted).
- Thread 5 retries 3 times, then succeeds; a later busy hit gives cpu_retry=1 with cnt=1. Interleaved busy hits from thread 6 do not change thread 5's count.
- slv_irl = {4'h3, 4'h0, 4'hA, 4'h1}. Expect cpu_irl=4'hA in the same cycle; all slv_irl=0 gives cpu_irl=0.
- Assert rst while a busy request is in XC. Expect slv_req=0, and all counters and outputs 0 on the next cycle. With IO_SWITCH_STATS_EN: 3 successes plus 2 retries, then a read of 0xFFFF8 returns 3 and 0xFFFFC returns 2.
